imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the instruction-memory word-address width.
REQ-002 SHALL have parameter DEPTH, default 1024, meaning the maximum payload words accepted (DEPTH <= 2**ADDR_W).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  single-cycle pulse; opens a new load session.
REQ-006 word_in  in  32  assembled word from the upstream byte-to-word buffer filler.
REQ-007 word_valid  in  1  single-cycle pulse; word_in is valid in that cycle.
REQ-008 mem_we  out  1  instruction-memory write enable.
REQ-009 mem_addr  out  ADDR_W  word address for the write.
REQ-010 mem_wdata  out  32  write data.
REQ-011 cpu_hold  out  1  holds the core in reset while high.
REQ-012 busy  out  1  high in WAIT_LEN, LOAD and CHECK.
REQ-013 load_done  out  1  level; high in DONE.
REQ-014 err_len  out  1  level; length word illegal.
REQ-015 err_csum  out  1  level; checksum mismatch.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT_LEN, LOAD, CHECK, DONE, ERROR.
REQ-017 IDLE, DONE, ERROR: start -> WAIT_LEN; clears address, counter, checksum accumulator, load_done, err_len and err_csum.
REQ-018 WAIT_LEN: first word_valid carries payload length L; L==0 or L>DEPTH -> ERROR with err_len=1; otherwise store L -> LOAD.
REQ-019 LOAD: each word_valid SHALL produce exactly one write: mem_we=1 in the following cycle, with mem_addr = current index (starting at 0) and mem_wdata = word_in.
REQ-020 Write latency SHALL be exactly one cycle from word_valid to mem_we; mem_we SHALL be high for one cycle per word and low otherwise.
REQ-021 After the L-th payload word, the FSM SHALL go to CHECK (macro defined) or DONE (macro undefined) in the same cycle that mem_we asserts.
REQ-022 The index SHALL count 0..L-1 without wrap-around; L<=DEPTH guarantees no address overflow.
REQ-023 cpu_hold SHALL be 1 in every state except DONE; it falls in the first cycle of DONE.
REQ-024 word_valid in IDLE, DONE or ERROR SHALL be ignored: no write and no state change.
REQ-025 start in WAIT_LEN, LOAD or CHECK SHALL abort the session and restart at WAIT_LEN with index 0; a write already registered for a previous word_valid still completes.
REQ-026 If start and word_valid coincide, start SHALL win and the word SHALL be discarded.
REQ-027 busy SHALL equal (state in {WAIT_LEN, LOAD, CHECK}).

Reset
REQ-028 On rst: state=IDLE, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, busy=0, load_done=0, err_len=0, err_csum=0, index and accumulator 0.
REQ-029 rst asserted mid-session SHALL abandon the session immediately; a pending write SHALL NOT be issued.

Configuration
REQ-030 With macro IMEM_LOADER_CHECKSUM_EN defined: a 32-bit accumulator sums payload words mod 2**32, and the word after the payload is compared in CHECK; match -> DONE, mismatch -> ERROR with err_csum=1; the checksum word is never written to memory.
REQ-031 Without IMEM_LOADER_CHECKSUM_EN: CHECK and the accumulator are absent, LOAD goes straight to DONE, and err_csum is tied to 0.

Verification
REQ-032 start; words 0x00000003, 0xA, 0xB, 0xC -> writes (0,0xA), (1,0xB), (2,0xC), each one cycle after its word_valid; with the macro off: load_done=1 and cpu_hold=0 immediately after the third write.
REQ-033 Macro on: same stream plus 0x00000021 -> DONE; plus 0x00000022 -> ERROR with err_csum=1, cpu_hold=1, load_done=0.
REQ-034 Length word 0x0 and, separately, DEPTH+1 -> ERROR with err_len=1 and no mem_we pulse.
REQ-035 start; length 4; two words; start again; length 1; word 0x55 -> final write (0,0x55) then DONE; start coinciding with word_valid -> no write for that word.
REQ-036 rst pulse in the cycle after a LOAD word_valid -> no mem_we, all outputs at reset values, cpu_hold=1; word_valid while IDLE -> no write.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a length word and L payload words, writes them to IMEM, then releases cpu_hold.
// Optional trailing checksum word is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       word_in,
  input  logic              word_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              load_done,
  output logic              err_len,
  output logic              err_csum
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_LEN,
    ST_LOAD,
    ST_DONE,
    ST_ERROR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , ST_CHECK
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] len_m1_q, len_m1_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              err_len_q, err_len_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]       acc_q, acc_d;
  logic              err_csum_q, err_csum_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      len_m1_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_len_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc_q       <= '0;
      err_csum_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_m1_q    <= len_m1_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_len_q   <= err_len_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc_q       <= acc_d;
      err_csum_q  <= err_csum_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_m1_d    = len_m1_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_len_d   = err_len_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    acc_d       = acc_q;
    err_csum_d  = err_csum_q;
`endif
    // start opens a fresh session from any state and always beats a coincident word
    if (start) begin
      state_d   = ST_WAIT_LEN;
      idx_d     = '0;
      err_len_d = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc_d      = '0;
      err_csum_d = 1'b0;
`endif
    end else if (word_valid) begin
      case (state_q)
        ST_WAIT_LEN: begin
          if (word_in == 32'd0 || word_in > DEPTH_W) begin
            state_d   = ST_ERROR;
            err_len_d = 1'b1;
          end else begin
            // L <= 2**ADDR_W, so L-1 always fits in the index width
            len_m1_d = word_in[ADDR_W-1:0] - ADDR_W'(1);
            state_d  = ST_LOAD;
          end
        end
        ST_LOAD: begin
          mem_we_d    = 1'b1;
          mem_addr_d  = idx_q;
          mem_wdata_d = word_in;
`ifdef IMEM_LOADER_CHECKSUM_EN
          acc_d = acc_q + word_in;
`endif
          if (idx_q == len_m1_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_DONE;
`endif
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (word_in == acc_q) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_ERROR;
            err_csum_d = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = (state_q != ST_DONE);
  assign load_done = (state_q == ST_DONE);
  assign err_len   = err_len_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign busy     = (state_q == ST_WAIT_LEN) || (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign err_csum = err_csum_q;
`else
  assign busy     = (state_q == ST_WAIT_LEN) || (state_q == ST_LOAD);
  assign err_csum = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: scoreboard of expected IMEM writes plus status-level checks.
module tb_imem_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [31:0]       word_in;
  logic              word_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              load_done;
  logic              err_len;
  logic              err_csum;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .word_in(word_in), .word_valid(word_valid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .busy(busy), .load_done(load_done), .err_len(err_len), .err_csum(err_csum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // every mem_we pulse must match the oldest expected write
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_write", {31'b0, mem_we}, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {22'b0, mem_addr}, e.addr);
        chk("wr_data", mem_wdata, e.data);
      end
    end
  end

  task automatic send(input logic [31:0] w);
    @(negedge clk);
    word_in    = w;
    word_valid = 1'b1;
    @(negedge clk);
    word_valid = 1'b0;
  endtask

  task automatic payload(input logic [31:0] a, input logic [31:0] w);
    exp_q.push_back('{addr: a, data: w});
    send(w);
    chk("we_latency", {31'b0, mem_we}, 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"},        {31'b0, mem_we},    32'd0);
    chk({tag, "_addr"},      {22'b0, mem_addr},  32'd0);
    chk({tag, "_wdata"},     mem_wdata,          32'd0);
    chk({tag, "_cpu_hold"},  {31'b0, cpu_hold},  32'd1);
    chk({tag, "_busy"},      {31'b0, busy},      32'd0);
    chk({tag, "_load_done"}, {31'b0, load_done}, 32'd0);
    chk({tag, "_err_len"},   {31'b0, err_len},   32'd0);
    chk({tag, "_err_csum"},  {31'b0, err_csum},  32'd0);
  endtask

  // finishes a session whose payload has just been written
  task automatic finish_ok(input string tag, input logic [31:0] csum);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk({tag, "_wait_csum_done"}, {31'b0, load_done}, 32'd0);
    chk({tag, "_wait_csum_busy"}, {31'b0, busy},      32'd1);
    send(csum);
    chk({tag, "_csum_not_written"}, {31'b0, mem_we}, 32'd0);
`else
    chk({tag, "_csum_unused"}, csum, csum);
`endif
    chk({tag, "_load_done"}, {31'b0, load_done}, 32'd1);
    chk({tag, "_cpu_hold"},  {31'b0, cpu_hold},  32'd0);
    chk({tag, "_busy"},      {31'b0, busy},      32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; word_valid = 1'b0; word_in = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    // word while idle is ignored
    send(32'h0000_0099);
    chk("idle_word_busy", {31'b0, busy}, 32'd0);

    // basic load of three words
    pulse_start();
    chk("start_busy", {31'b0, busy}, 32'd1);
    chk("start_hold", {31'b0, cpu_hold}, 32'd1);
    send(32'd3);
    payload(32'd0, 32'h0000_000A);
    chk("mid_load_done", {31'b0, load_done}, 32'd0);
    payload(32'd1, 32'h0000_000B);
    payload(32'd2, 32'h0000_000C);
    finish_ok("basic", 32'h0000_0021);
    @(negedge clk);
    chk("we_one_cycle", {31'b0, mem_we}, 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_start();
    send(32'd3);
    payload(32'd0, 32'h0000_000A);
    payload(32'd1, 32'h0000_000B);
    payload(32'd2, 32'h0000_000C);
    send(32'h0000_0022);
    chk("csum_bad_err", {31'b0, err_csum}, 32'd1);
    chk("csum_bad_hold", {31'b0, cpu_hold}, 32'd1);
    chk("csum_bad_done", {31'b0, load_done}, 32'd0);
    chk("csum_bad_we", {31'b0, mem_we}, 32'd0);
`endif

    // illegal lengths
    pulse_start();
    send(32'd0);
    chk("len0_err", {31'b0, err_len}, 32'd1);
    chk("len0_busy", {31'b0, busy}, 32'd0);
    chk("len0_hold", {31'b0, cpu_hold}, 32'd1);
    send(32'h0000_1234);
    pulse_start();
    chk("restart_clears_err", {31'b0, err_len}, 32'd0);
    send(DEPTH + 1);
    chk("lenmax_err", {31'b0, err_len}, 32'd1);
    chk("lenmax_done", {31'b0, load_done}, 32'd0);

    // abort mid-load and restart
    pulse_start();
    send(32'd4);
    payload(32'd0, 32'h0000_0011);
    payload(32'd1, 32'h0000_0022);
    pulse_start();
    chk("abort_busy", {31'b0, busy}, 32'd1);
    send(32'd1);
    payload(32'd0, 32'h0000_0055);
    finish_ok("abort", 32'h0000_0055);

    // start coinciding with word_valid discards the word
    pulse_start();
    send(32'd2);
    payload(32'd0, 32'h0000_0001);
    @(negedge clk);
    start = 1'b1; word_valid = 1'b1; word_in = 32'h0000_DEAD;
    @(negedge clk);
    start = 1'b0; word_valid = 1'b0;
    chk("coincide_no_we", {31'b0, mem_we}, 32'd0);
    chk("coincide_busy", {31'b0, busy}, 32'd1);
    send(32'd1);
    payload(32'd0, 32'h0000_0077);
    finish_ok("coincide", 32'h0000_0077);

    // reset right after a payload word kills the pending write
    pulse_start();
    send(32'd2);
    @(negedge clk);
    word_in = 32'h0000_00AA; word_valid = 1'b1;
    @(posedge clk);
    #1 word_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("midrst");
    rst = 1'b0;
    send(32'h0000_0042);
    chk("post_rst_idle_we", {31'b0, mem_we}, 32'd0);
    chk("post_rst_idle_busy", {31'b0, busy}, 32'd0);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
